// File: rtl/cmp_pkg.sv
// Shared constants and FSM state type for the serial 32-bit comparator.
package cmp_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        EVAL = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/zero_cmp32bit.sv
// Zero / sign detector on a 32-bit difference: eq when all bits clear, lt from the sign bit.
module zero_cmp32bit
    import cmp_pkg::*;
(
    input  logic [WORD_W-1:0] diff_i,
    output logic              eq_o,
    output logic              lt_o
);

    // Pure combinational decode; the caller registers the results.
    always_comb begin
        eq_o = (diff_i == {WORD_W{1'b0}});
        lt_o = diff_i[WORD_W-1];
    end

endmodule

// File: rtl/serial_cmp32bit_ctrl.sv
// Multi-cycle 32-bit magnitude comparator: subtracts a-b one SLICE_W-bit slice per
// cycle (LSB first), then classifies the difference as lt / eq / gt.
module serial_cmp32bit_ctrl
    import cmp_pkg::*;
#(
    parameter int SLICE_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              signed_mode,
    output logic              busy,
    output logic              done,
    output logic              lt,
    output logic              eq,
    output logic              gt
);

    localparam int N     = WORD_W / SLICE_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    state_e              state_q;
    state_e              state_d;
    logic [WORD_W-1:0]   a_q;
    logic [WORD_W-1:0]   b_q;
    logic [WORD_W-1:0]   diff_q;
    logic                smode_q;
    logic                borrow_q;
    logic [IDX_W-1:0]    idx_q;
    logic                busy_q;
    logic                busy_d;
    logic                done_q;
    logic                done_d;
    logic                lt_q;
    logic                eq_q;
    logic                gt_q;

    logic [SLICE_W-1:0]  a_slice_s;
    logic [SLICE_W-1:0]  b_slice_s;
    logic [SLICE_W:0]    sub_s;
    logic                last_slice_s;
    logic                load_s;
    logic                zc_eq_s;
    logic                zc_lt_s;
    logic                ovf_s;
    logic                lt_s;
    logic                gt_s;

    zero_cmp32bit u_zero_cmp (
        .diff_i (diff_q),
        .eq_o   (zc_eq_s),
        .lt_o   (zc_lt_s)
    );

    // Inline slice subtractor; the extra MSB of sub_s is the borrow-out.
    always_comb begin
        a_slice_s    = a_q[idx_q*SLICE_W +: SLICE_W];
        b_slice_s    = b_q[idx_q*SLICE_W +: SLICE_W];
        sub_s        = {1'b0, a_slice_s} - {1'b0, b_slice_s} - {{SLICE_W{1'b0}}, borrow_q};
        last_slice_s = (idx_q == IDX_W'(N - 1));
        load_s       = ((state_q == IDLE) || (state_q == DONE)) && start;
    end

    // Result classification from the completed difference.
    always_comb begin
        ovf_s = (a_q[WORD_W-1] != b_q[WORD_W-1]) && (diff_q[WORD_W-1] != a_q[WORD_W-1]);
        if (smode_q) begin
            lt_s = zc_lt_s ^ ovf_s;
        end else begin
            lt_s = borrow_q;
        end
        gt_s = !lt_s && !zc_eq_s;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? SUB : IDLE;
            SUB:     state_d = last_slice_s ? EVAL : SUB;
            EVAL:    state_d = DONE;
            DONE:    state_d = start ? SUB : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs, decoded from the next state so the flops line up with it.
    always_comb begin
        busy_d = (state_d == SUB) || (state_d == EVAL);
        done_d = (state_d == DONE);
    end

    // Registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    // Operand capture and slice-serial subtraction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q      <= {WORD_W{1'b0}};
            b_q      <= {WORD_W{1'b0}};
            smode_q  <= 1'b0;
            diff_q   <= {WORD_W{1'b0}};
            borrow_q <= 1'b0;
            idx_q    <= {IDX_W{1'b0}};
        end else if (load_s) begin
            a_q      <= a;
            b_q      <= b;
            smode_q  <= signed_mode;
            borrow_q <= 1'b0;
            idx_q    <= {IDX_W{1'b0}};
        end else if (state_q == SUB) begin
            diff_q[idx_q*SLICE_W +: SLICE_W] <= sub_s[SLICE_W-1:0];
            borrow_q <= sub_s[SLICE_W];
            idx_q    <= idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
        end else begin
            idx_q    <= idx_q;
        end
    end

    // Results only change on the EVAL edge and are held otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lt_q <= 1'b0;
            eq_q <= 1'b0;
            gt_q <= 1'b0;
        end else if (state_q == EVAL) begin
            lt_q <= lt_s;
            eq_q <= zc_eq_s;
            gt_q <= gt_s;
        end else begin
            lt_q <= lt_q;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign lt   = lt_q;
    assign eq   = eq_q;
    assign gt   = gt_q;

endmodule

// File: tb/tb_serial_cmp32bit_ctrl.sv
// Directed bench for serial_cmp32bit_ctrl with SLICE_W=8 (four slices per compare).
module tb_serial_cmp32bit_ctrl;

    localparam int SLICE_W = 8;
    localparam int N       = 32 / SLICE_W;
    localparam int TMO     = 20;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        signed_mode;
    logic        busy;
    logic        done;
    logic        lt;
    logic        eq;
    logic        gt;

    int n_checks;
    int n_errors;

    serial_cmp32bit_ctrl #(.SLICE_W(SLICE_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .busy        (busy),
        .done        (done),
        .lt          (lt),
        .eq          (eq),
        .gt          (gt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmp(input logic [31:0] av, input logic [31:0] bv, input logic sm);
        a           = av;
        b           = bv;
        signed_mode = sm;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    // Waits for done; lat counts edges after the start edge, bcnt counts busy samples.
    task automatic wait_done(input string tag, output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (!done && lat < TMO) begin
            if (busy) bcnt++;
            tick();
            lat++;
        end
        check({tag, "_timeout"}, 32'(lat < TMO), 32'd1);
    endtask

    int lat;
    int bcnt;

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        reset_n     = 1'b0;
        start       = 1'b0;
        a           = 32'd0;
        b           = 32'd0;
        signed_mode = 1'b0;
        #2;
        check("reset_outs", {27'd0, busy, done, lt, eq, gt}, 32'd0);
        tick();
        tick();
        reset_n = 1'b1;

        // Unsigned 5 vs 3: latency, busy length, one-cycle done.
        start_cmp(32'd5, 32'd3, 1'b0);
        a = 32'd0;
        b = 32'd100;
        wait_done("u5_3", lat, bcnt);
        check("u5_3_lat", 32'(lat), 32'(N + 1));
        check("u5_3_busy_cycles", 32'(bcnt), 32'(N + 1));
        check("u5_3_busy_at_done", {31'd0, busy}, 32'd0);
        check("u5_3_res", {29'd0, lt, eq, gt}, 32'b001);
        tick();
        check("u5_3_done_pulse", {31'd0, done}, 32'd0);

        // Overflow case, signed then unsigned.
        start_cmp(32'h8000_0000, 32'h0000_0001, 1'b1);
        wait_done("ovf_s", lat, bcnt);
        check("ovf_s_res", {29'd0, lt, eq, gt}, 32'b100);
        tick();
        start_cmp(32'h8000_0000, 32'h0000_0001, 1'b0);
        wait_done("ovf_u", lat, bcnt);
        check("ovf_u_res", {29'd0, lt, eq, gt}, 32'b001);
        tick();

        // Borrow must ripple through every slice.
        start_cmp(32'h0000_0000, 32'h0000_0001, 1'b0);
        wait_done("bor_u", lat, bcnt);
        check("bor_u_res", {29'd0, lt, eq, gt}, 32'b100);
        tick();
        start_cmp(32'h0000_0100, 32'h0000_00FF, 1'b0);
        wait_done("carry_u", lat, bcnt);
        check("carry_u_res", {29'd0, lt, eq, gt}, 32'b001);
        tick();
        start_cmp(32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        wait_done("neg1_s", lat, bcnt);
        check("neg1_s_res", {29'd0, lt, eq, gt}, 32'b100);
        tick();

        // Equal operands, then results held through idle cycles.
        start_cmp(32'h0C00_3038, 32'h0C00_3038, 1'b0);
        wait_done("equal", lat, bcnt);
        check("equal_res", {29'd0, lt, eq, gt}, 32'b010);
        for (int i = 0; i < 10; i++) tick();
        check("equal_held", {28'd0, done, lt, eq, gt}, 32'b0010);

        // Second start while busy is ignored; operand changes do not leak in.
        start_cmp(32'd1, 32'd2, 1'b0);
        tick();
        start_cmp(32'd9, 32'd0, 1'b0);
        wait_done("ign", lat, bcnt);
        check("ign_lat", 32'(lat), 32'(N - 1));
        check("ign_res", {29'd0, lt, eq, gt}, 32'b100);
        for (int i = 0; i < 3; i++) tick();
        check("ign_no_rerun", {30'd0, busy, done}, 32'd0);

        // Reset mid-SUB clears outputs without a clock edge; no done afterwards.
        start_cmp(32'd5, 32'd3, 1'b0);
        tick();
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_mid_outs", {27'd0, busy, done, lt, eq, gt}, 32'd0);
        tick();
        reset_n = 1'b1;
        bcnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done || busy) bcnt++;
        end
        check("rst_no_done", 32'(bcnt), 32'd0);
        start_cmp(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        wait_done("post_rst", lat, bcnt);
        check("post_rst_lat", 32'(lat), 32'(N + 1));
        check("post_rst_res", {29'd0, lt, eq, gt}, 32'b100);

        // Back-to-back: start held in the DONE cycle.
        tick();
        start_cmp(32'd5, 32'd3, 1'b0);
        wait_done("b2b_1", lat, bcnt);
        check("b2b_1_res", {29'd0, lt, eq, gt}, 32'b001);
        start_cmp(32'd1, 32'd2, 1'b0);
        check("b2b_busy", {30'd0, busy, done}, 32'b10);
        check("b2b_held", {29'd0, lt, eq, gt}, 32'b001);
        wait_done("b2b_2", lat, bcnt);
        check("b2b_gap", 32'(lat + 1), 32'(N + 2));
        check("b2b_2_res", {29'd0, lt, eq, gt}, 32'b100);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
